// File: rtl/silife_pkg.sv
// Shared constants and types for the SILIFE MAX7219-format SPI loader.
package silife_pkg;

    localparam logic [3:0] REG_NOOP      = 4'h0;
    localparam logic [3:0] REG_DIGIT0    = 4'h1;
    localparam logic [3:0] REG_DIGIT7    = 4'h8;
    localparam logic [3:0] REG_INTENSITY = 4'hA;
    localparam logic [3:0] REG_SHUTDOWN  = 4'hC;

    localparam int unsigned CHAIN_DEFAULT = 4;
    localparam int unsigned FRAME_BITS    = 16 * CHAIN_DEFAULT;

    typedef enum logic {
        StIdle,
        StCommit
    } loader_state_e;

    function automatic int unsigned frame_bits(input int unsigned chain);
        return 16 * chain;
    endfunction

endpackage

// File: rtl/silife_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with single-cycle rise/fall pulses.
module silife_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0] metastability flop, [1] synchronised level, [2] previous level
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {3{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/silife_spi_loader.sv
// MAX7219-format SPI receiver that turns each frame into grid row writes.
// Build option: define SILIFE_LOADER_CTRL_REGS_EN to decode intensity/shutdown registers.
module silife_spi_loader
    import silife_pkg::*;
#(
    parameter int unsigned CHAIN    = CHAIN_DEFAULT,
    parameter int unsigned ROW_BITS = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_cs,
    input  logic                i_sck,
    input  logic                i_mosi,
    output logic [ROW_BITS-1:0] o_row_select,
    output logic [7:0]          o_row_data,
    output logic                o_row_wr,
    output logic [3:0]          o_brightness,
    output logic                o_shutdown,
    output logic                o_frame_err,
    output logic                o_busy
);

    localparam int unsigned FBITS = frame_bits(CHAIN);
    localparam int unsigned CNT_W = $clog2(FBITS + 2);
    localparam int unsigned DEV_W = (CHAIN > 1) ? $clog2(CHAIN) : 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FBITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FBITS + 1);
    localparam logic [DEV_W-1:0] DEV_LAST = DEV_W'(CHAIN - 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sck_lvl, sck_rise, sck_fall;
    logic unused_sck;

    silife_sync_edge #(
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (i_cs),
        .level (cs_lvl),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    silife_sync_edge #(
        .RESET_VAL (1'b0)
    ) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (i_sck),
        .level (sck_lvl),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    assign unused_sck = sck_lvl ^ sck_fall;

    // MOSI shares the SCK synchroniser depth so a sampled bit lines up with its edge
    logic [1:0] mosi_sync_q;
    logic       mosi_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
        end else begin
            mosi_sync_q <= {mosi_sync_q[0], i_mosi};
        end
    end

    assign mosi_s = mosi_sync_q[1];

    logic [FBITS-1:0] shift_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (cs_fall) begin
            cnt_q <= '0;
        end else if (sck_rise && !cs_lvl) begin
            shift_q <= {shift_q[FBITS-2:0], mosi_s};
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    loader_state_e    state_q, state_d;
    logic [DEV_W-1:0] dev_q, dev_d;
    logic [FBITS-1:0] hold_q;
    logic             start_q;
    logic             err_q;
    logic             frame_ok, frame_bad;

    // A full frame is only accepted when nothing is pending or being committed
    always_comb begin
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (cs_rise && (cnt_q != '0)) begin
            if ((cnt_q == CNT_FULL) && (state_q == StIdle) && !start_q) begin
                frame_ok = 1'b1;
            end else begin
                frame_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q  <= '0;
            start_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            start_q <= frame_ok;
            err_q   <= frame_bad;
            if (frame_ok) begin
                hold_q <= shift_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            dev_q   <= '0;
        end else begin
            state_q <= state_d;
            dev_q   <= dev_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dev_d   = dev_q;
        case (state_q)
            StIdle: begin
                if (start_q) begin
                    state_d = StCommit;
                    dev_d   = '0;
                end
            end
            StCommit: begin
                if (dev_q == DEV_LAST) begin
                    state_d = StIdle;
                end else begin
                    dev_d = dev_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The last word shifted in sits at the bottom and belongs to device 0
    logic [15:0]         word;
    logic [3:0]          addr;
    logic [7:0]          data;
    logic                is_row;
    logic [ROW_BITS-1:0] row_calc;
    logic                unused_hi;

    assign word      = hold_q[16*dev_q +: 16];
    assign addr      = word[11:8];
    assign data      = word[7:0];
    assign unused_hi = ^word[15:12];
    assign is_row    = (state_q == StCommit) && (addr >= REG_DIGIT0) && (addr <= REG_DIGIT7);
    assign row_calc  = ROW_BITS'({dev_q, 3'b000}) + ROW_BITS'(addr - REG_DIGIT0);

    logic                row_wr_q;
    logic [ROW_BITS-1:0] row_sel_q;
    logic [7:0]          row_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_wr_q   <= 1'b0;
            row_sel_q  <= '0;
            row_data_q <= '0;
        end else begin
            row_wr_q <= is_row;
            if (is_row) begin
                row_sel_q  <= row_calc;
                row_data_q <= data;
            end
        end
    end

`ifdef SILIFE_LOADER_CTRL_REGS_EN
    logic [3:0] bright_q;
    logic       shut_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 4'h0;
            shut_q   <= 1'b1;
        end else if (state_q == StCommit) begin
            case (addr)
                REG_INTENSITY: bright_q <= data[3:0];
                REG_SHUTDOWN:  shut_q   <= ~data[0];
                default: ;
            endcase
        end
    end

    assign o_brightness = bright_q;
    assign o_shutdown   = shut_q;
`else
    assign o_brightness = 4'hf;
    assign o_shutdown   = 1'b0;
`endif

    assign o_row_wr     = row_wr_q;
    assign o_row_select = row_sel_q;
    assign o_row_data   = row_data_q;
    assign o_frame_err  = err_q;
    assign o_busy       = (state_q == StCommit);

endmodule

// File: tb/tb_silife_spi_loader.sv
// Self-checking bench for silife_spi_loader: random frames against a word-level reference model.
module tb_silife_spi_loader;

    localparam int CHAIN    = 4;
    localparam int ROW_BITS = 5;
    localparam int FB       = 16 * CHAIN;

    logic                clk    = 1'b0;
    logic                rst_n  = 1'b0;
    logic                cs     = 1'b1;
    logic                sck    = 1'b0;
    logic                mosi   = 1'b0;
    logic [ROW_BITS-1:0] o_row_select;
    logic [7:0]          o_row_data;
    logic                o_row_wr;
    logic [3:0]          o_brightness;
    logic                o_shutdown;
    logic                o_frame_err;
    logic                o_busy;

    silife_spi_loader #(
        .CHAIN    (CHAIN),
        .ROW_BITS (ROW_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_cs         (cs),
        .i_sck        (sck),
        .i_mosi       (mosi),
        .o_row_select (o_row_select),
        .o_row_data   (o_row_data),
        .o_row_wr     (o_row_wr),
        .o_brightness (o_brightness),
        .o_shutdown   (o_shutdown),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int data;
        int t;
    } wr_t;

    wr_t obs[$];
    wr_t expq[$];
    int  cyc         = 0;
    int  err_pulses  = 0;
    int  busy_cycles = 0;
    int  checks      = 0;
    int  failures    = 0;
    int  exp_bri;
    int  exp_shut;
    int  rise_t;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (o_row_wr) begin
            w.row  = int'(o_row_select);
            w.data = int'(o_row_data);
            w.t    = cyc;
            obs.push_back(w);
        end
        if (o_frame_err) err_pulses++;
        if (o_busy) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
`ifdef SILIFE_LOADER_CTRL_REGS_EN
        exp_bri  = 0;
        exp_shut = 1;
`else
        exp_bri  = 15;
        exp_shut = 0;
`endif
    endtask

    // Word i is the i-th 16 bits on the wire and drives device CHAIN-1-i; devices commit 0 first
    task automatic model_frame(input logic [FB-1:0] f);
        for (int d = 0; d < CHAIN; d++) begin
            logic [15:0] w;
            int          i;
            int          a;
            wr_t         e;
            i = CHAIN - 1 - d;
            w = f[FB-1-16*i -: 16];
            a = int'(w[11:8]);
            if (a >= 1 && a <= 8) begin
                e.row  = d * 8 + a - 1;
                e.data = int'(w[7:0]);
                e.t    = 0;
                expq.push_back(e);
            end
`ifdef SILIFE_LOADER_CTRL_REGS_EN
            if (a == 10) exp_bri = int'(w[3:0]);
            if (a == 12) exp_shut = w[0] ? 0 : 1;
`endif
        end
    endtask

    function automatic logic [15:0] rand_word();
        logic [3:0] a;
        a = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
        return {4'($urandom), a, 8'($urandom)};
    endfunction

    function automatic logic [FB-1:0] rand_frame();
        return {rand_word(), rand_word(), rand_word(), rand_word()};
    endfunction

    task automatic cs_low();
        cs = 1'b0;
        tick(2);
    endtask

    task automatic cs_high(input int gap);
        cs     = 1'b1;
        rise_t = cyc;
        tick(gap);
    endtask

    // SCK = clk/4, MOSI set while SCK is low
    task automatic send_bits(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            sck  = 1'b0;
            tick(2);
            sck = 1'b1;
            tick(2);
        end
        sck = 1'b0;
        tick(2);
    endtask

    task automatic run_frame(input logic [FB-1:0] f);
        model_frame(f);
        cs_low();
        send_bits(128'(f), FB);
        cs_high(3);
        tick(15);
    endtask

    task automatic check_commit(input string tag, input bit consec);
        check({tag, "_nwr"}, 32'(obs.size()), 32'(expq.size()));
        if (obs.size() == expq.size()) begin
            foreach (expq[k]) begin
                check({tag, "_row"}, 32'(obs[k].row), 32'(expq[k].row));
                check({tag, "_data"}, 32'(obs[k].data), 32'(expq[k].data));
                if (consec && k > 0) check({tag, "_gap"}, 32'(obs[k].t - obs[k-1].t), 32'd1);
            end
        end
        if (expq.size() > 0) begin
            check({tag, "_hold_sel"}, 32'(o_row_select), 32'(expq[$].row));
            check({tag, "_hold_data"}, 32'(o_row_data), 32'(expq[$].data));
        end
        check({tag, "_bri"}, 32'(o_brightness), 32'(exp_bri));
        check({tag, "_shut"}, 32'(o_shutdown), 32'(exp_shut));
        obs.delete();
        expq.delete();
    endtask

    initial begin
        logic [FB-1:0] f;
        logic [FB-1:0] g;
        int            e0;
        int            b0;
        int            lat;

        model_reset();
        rst_n = 1'b0;
        tick(4);
        rst_n = 1'b1;
        tick(20);
        check("rst_nwr", 32'(obs.size()), 32'd0);
        check("rst_bri", 32'(o_brightness), 32'(exp_bri));
        check("rst_shut", 32'(o_shutdown), 32'(exp_shut));
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_err", 32'(err_pulses), 32'd0);
        check("rst_sel", 32'(o_row_select), 32'd0);
        check("rst_data", 32'(o_row_data), 32'd0);

        // Directed row frame
        f  = {16'h01A5, 16'h0100, 16'h0100, 16'h083C};
        b0 = busy_cycles;
        run_frame(f);
        lat = (obs.size() > 0) ? (obs[0].t - rise_t) : -1;
        check("dir_latency_ok", 32'((lat >= 4 && lat <= 6) ? 1 : 0), 32'd1);
        check("dir_busy_len", 32'(busy_cycles - b0), 32'(CHAIN));
        check_commit("dir", 1'b1);

        // Control-register frame
        run_frame({16'h0A07, 16'h0000, 16'h0000, 16'h0C01});
        check_commit("ctrl", 1'b0);

        // Short and long frames are discarded
        e0 = err_pulses;
        cs_low();
        send_bits({$urandom, $urandom, $urandom, $urandom}, FB - 1);
        cs_high(3);
        tick(10);
        check("short_err", 32'(err_pulses), 32'(e0 + 1));
        cs_low();
        send_bits({$urandom, $urandom, $urandom, $urandom}, FB + 1);
        cs_high(3);
        tick(10);
        check("long_err", 32'(err_pulses), 32'(e0 + 2));
        check("bad_nwr", 32'(obs.size()), 32'd0);
        run_frame(rand_frame());
        check_commit("after_bad", 1'b0);

        // CS toggle with no clocks is silently ignored
        e0 = err_pulses;
        cs_low();
        cs_high(10);
        check("empty_err", 32'(err_pulses), 32'(e0));

        // Back-to-back frames, one clk of CS high between them
        f = rand_frame();
        g = rand_frame();
        model_frame(f);
        model_frame(g);
        e0 = err_pulses;
        cs_low();
        send_bits(128'(f), FB);
        cs_high(1);
        cs_low();
        send_bits(128'(g), FB);
        cs_high(3);
        tick(15);
        check("b2b_err", 32'(err_pulses), 32'(e0));
        check_commit("b2b", 1'b0);

        // Reset mid-frame
        e0 = err_pulses;
        cs_low();
        send_bits({$urandom, $urandom, $urandom, $urandom}, 40);
        rst_n = 1'b0;
        tick(2);
        cs = 1'b1;
        tick(2);
        rst_n = 1'b1;
        model_reset();
        tick(10);
        check("midrst_nwr", 32'(obs.size()), 32'd0);
        check("midrst_err", 32'(err_pulses), 32'(e0));
        check("midrst_bri", 32'(o_brightness), 32'(exp_bri));
        check("midrst_shut", 32'(o_shutdown), 32'(exp_shut));
        run_frame(rand_frame());
        check_commit("post_rst", 1'b0);

        // Random frames
        for (int n = 0; n < 8; n++) begin
            run_frame(rand_frame());
            check_commit("rand", 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
